// File: rtl/fx3_pkg.sv
// fx3_pkg: shared state encoding, sizes and sample scaling for the FX3 transmit path
package fx3_pkg;
  typedef enum logic [1:0] {IDLE, BURST, HOLDOFF} state_e;
  localparam int BURST_WORDS_DEF = 8192;
  localparam int SCALE_SHIFT = 6;
  localparam int BUS_W = 16;
  localparam int SAMPLE_W = BUS_W - SCALE_SHIFT;
  function automatic logic [BUS_W-1:0] scale(input logic [SAMPLE_W-1:0] s);
    return {s, {SCALE_SHIFT{1'b0}}};
  endfunction
endpackage

// File: rtl/fx3_stream_tx_test_pattern_gen.sv
// test_pattern_gen: wrapping sample-width counter used as a substitute data source
module test_pattern_gen
  import fx3_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                adv_i,
  output logic [SAMPLE_W-1:0] pattern_o
);
  logic [SAMPLE_W-1:0] pattern_q;
  // advance once per enabled cycle, wrapping naturally at the top value
  always_ff @(posedge clk_i or posedge rst_i)
    pattern_q <= rst_i ? '0 : adv_i ? pattern_q + 1'b1 : pattern_q;
  assign pattern_o = pattern_q;
endmodule

// File: rtl/fx3_stream_tx.sv
// fx3_stream_tx: streams one full burst of FIFO samples onto the FX3 bus per ready handshake
module fx3_stream_tx
  import fx3_pkg::*;
#(
  parameter int BURST_WORDS    = BURST_WORDS_DEF,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fifo_data_ready_i,
  input  logic                fifo_error_i,
  input  logic [SAMPLE_W-1:0] fifo_data_i,
  output logic                fifo_ack_o,
  input  logic                fx3_ready_i,
  input  logic                test_mode_i,
  output logic [BUS_W-1:0]    fx3_data_o,
  output logic                fx3_write_o,
  output logic                burst_done_o,
  output logic                error_flag_o
);
  localparam int CNT_MAX = (BURST_WORDS > HOLDOFF_CYCLES) ? BURST_WORDS : HOLDOFF_CYCLES;
  localparam int CW = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic                burst_test_q;
  logic [BUS_W-1:0]    fx3_data_q;
  logic                fx3_write_q;
  logic                burst_done_q;
  logic                error_q;
  logic [SAMPLE_W-1:0] pattern;
  logic                last;
  assign last = cnt_q == CW'(BURST_WORDS - 1);
  assign fifo_ack_o = state_q == BURST;
  test_pattern_gen u_pattern (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .adv_i    (fifo_ack_o && burst_test_q),
    .pattern_o(pattern)
  );
  // burst sequencing plus the bus register stage; HOLDOFF spans HOLDOFF_CYCLES-1 cycles so
  // IDLE samples the ready condition on the HOLDOFF_CYCLES-th edge after the final ack
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      burst_test_q <= 1'b0;
      fx3_data_q   <= '0;
      fx3_write_q  <= 1'b0;
      burst_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      error_q      <= error_q | fifo_error_i;
      fx3_write_q  <= state_q == BURST;
      burst_done_q <= state_q == BURST && last;
      if (state_q == BURST) fx3_data_q <= burst_test_q ? scale(pattern) : scale(fifo_data_i);
      case (state_q)
        IDLE: if (fifo_data_ready_i && fx3_ready_i) begin
          state_q      <= BURST;
          burst_test_q <= test_mode_i;
        end
        BURST: begin
          state_q <= last ? (HOLDOFF_CYCLES > 1 ? HOLDOFF : IDLE) : BURST;
          cnt_q   <= last ? '0 : cnt_q + 1'b1;
        end
        HOLDOFF: begin
          state_q <= (cnt_q == CW'(HOLDOFF_CYCLES - 2)) ? IDLE : HOLDOFF;
          cnt_q   <= (cnt_q == CW'(HOLDOFF_CYCLES - 2)) ? '0 : cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign fx3_data_o   = fx3_data_q;
  assign fx3_write_o  = fx3_write_q;
  assign burst_done_o = burst_done_q;
  assign error_flag_o = error_q;
endmodule

// File: tb/tb_fx3_stream_tx.sv
// tb_fx3_stream_tx: randomized burst scenarios checked against a timing/data model of the transmit engine
`timescale 1ns/1ps
module tb_fx3_stream_tx;
  localparam int BW = 8192;
  localparam int HO = 4;
  localparam int L  = BW + HO + 2;
  logic clk = 0, rst = 1, fifo_rdy = 0, fifo_err = 0, fx3_rdy = 0, tm = 0;
  logic [9:0] fifo_data;
  logic ack, wr, done, err;
  logic [15:0] data;
  logic [9:0] samp [65536];
  int rd = 0, tests = 0, failed = 0, base = 0, pat_model = 0;
  logic [15:0] last_data = 0;
  logic c_ack [L+1];
  logic c_wr [L+1];
  logic c_done [L+1];
  logic [15:0] c_data [L+1];

  fx3_stream_tx #(.BURST_WORDS(BW), .HOLDOFF_CYCLES(HO)) dut (
    .clk_i(clk), .rst_i(rst), .fifo_data_ready_i(fifo_rdy), .fifo_error_i(fifo_err),
    .fifo_data_i(fifo_data), .fifo_ack_o(ack), .fx3_ready_i(fx3_rdy), .test_mode_i(tm),
    .fx3_data_o(data), .fx3_write_o(wr), .burst_done_o(done), .error_flag_o(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ack) rd <= rd + 1;
  assign fifo_data = samp[rd & 16'hFFFF];

  function automatic logic [15:0] exp_data(input int p, input logic t);
    int j;
    if (p < 2) return last_data;
    j = (p - 2 < BW) ? p - 2 : BW - 1;
    return t ? {10'((pat_model + j) % 1024), 6'b0} : {samp[(base + j) & 16'hFFFF], 6'b0};
  endfunction

  function automatic logic [18:0] exp_vec(input int p, input logic t, input bit keep);
    int q;
    q = keep ? ((p - 1) % (BW + HO)) + 1 : p;
    return {1'(q >= 1 && q <= BW), 1'(p >= 2 && p <= BW + 1), 1'(p == BW + 1), exp_data(p, t)};
  endfunction

  task automatic advance_model(input logic t);
    last_data = exp_data(BW + 1, t);
    if (t) pat_model = (pat_model + BW) % 1024;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1; fifo_rdy = 0; fx3_rdy = 0; tm = 0;
    repeat (2) @(negedge clk);
    rst = 0; pat_model = 0; last_data = 0;
  endtask

  task automatic run_burst(input logic t, input int len, input int drop_p, input bit tog);
    fifo_rdy = 0; fx3_rdy = 0;
    repeat (HO + 2) @(negedge clk);
    fifo_rdy = 1; fx3_rdy = 1; tm = t;
    @(posedge clk);
    base = rd;
    for (int p = 1; p <= len; p++) begin
      @(negedge clk);
      c_ack[p] = ack; c_wr[p] = wr; c_done[p] = done; c_data[p] = data;
      if (p == drop_p) begin fifo_rdy = 0; fx3_rdy = 0; end
      if (tog) tm = 1'($urandom);
    end
  endtask

  task automatic test_reset;
    fifo_rdy = 1; fx3_rdy = 1;
    repeat (3) @(negedge clk);
    tests++;
    if ({ack, wr, done, err} !== 4'b0) begin
      failed++; $display("FAIL reset_ctrl: got %b expected 0000", {ack, wr, done, err});
    end
    tests++;
    if (data !== 16'h0000) begin
      failed++; $display("FAIL reset_data: got %h expected 0000", data);
    end
    fifo_rdy = 0; fx3_rdy = 0;
    @(negedge clk); rst = 0;
  endtask

  task automatic test_basic;
    int bad = 0, na = 0, nw = 0;
    logic [18:0] gv = 0, ev = 0;
    samp[rd & 16'hFFFF] = 10'd1;
    samp[(rd + 1) & 16'hFFFF] = 10'h3FF;
    run_burst(0, BW + 2, 1, 0);
    for (int p = 1; p <= BW + 2; p++) begin
      na += c_ack[p]; nw += c_wr[p];
      if (bad == 0 && {c_ack[p], c_wr[p], c_done[p], c_data[p]} !== exp_vec(p, 0, 0)) begin
        bad = p; gv = {c_ack[p], c_wr[p], c_done[p], c_data[p]}; ev = exp_vec(p, 0, 0);
      end
    end
    tests++;
    if (bad !== 0) begin failed++; $display("FAIL basic_burst: period %0d got %h expected %h", bad, gv, ev); end
    tests++;
    if (na !== BW) begin failed++; $display("FAIL basic_ack_count: got %0d expected %0d", na, BW); end
    tests++;
    if (nw !== BW) begin failed++; $display("FAIL basic_write_count: got %0d expected %0d", nw, BW); end
    tests++;
    if (c_data[2] !== 16'h0040) begin failed++; $display("FAIL basic_sample1: got %h expected 0040", c_data[2]); end
    tests++;
    if (c_data[3] !== 16'hFFC0) begin failed++; $display("FAIL basic_fullscale: got %h expected ffc0", c_data[3]); end
    advance_model(0);
  endtask

  task automatic test_ready_gating;
    int bad = 0, na = 0, k = 0;
    logic [18:0] gv = 0, ev = 0;
    fifo_rdy = 1; fx3_rdy = 0;
    repeat (100) begin @(negedge clk); na += ack; end
    tests++;
    if (na !== 0) begin failed++; $display("FAIL gating_no_ack: got %0d acks expected 0", na); end
    run_burst(0, BW + HO + 1, 0, 0);
    for (int p = 1; p <= BW + HO + 1; p++)
      if (bad == 0 && {c_ack[p], c_wr[p], c_done[p], c_data[p]} !== exp_vec(p, 0, 1)) begin
        bad = p; gv = {c_ack[p], c_wr[p], c_done[p], c_data[p]}; ev = exp_vec(p, 0, 1);
      end
    tests++;
    if (bad !== 0) begin failed++; $display("FAIL gating_burst: period %0d got %h expected %h", bad, gv, ev); end
    tests++;
    if ({c_ack[BW + HO], c_ack[BW + HO + 1]} !== 2'b01) begin
      failed++; $display("FAIL gating_holdoff: got %b expected 01", {c_ack[BW + HO], c_ack[BW + HO + 1]});
    end
    fifo_rdy = 0; fx3_rdy = 0;
    while (ack === 1'b1 && k < BW + 20) begin @(negedge clk); k++; end
    tests++;
    if (ack !== 1'b0) begin failed++; $display("FAIL gating_drain: got ack %b expected 0 after %0d cycles", ack, k); end
    last_data = {samp[(base + 2 * BW - 1) & 16'hFFFF], 6'b0};
  endtask

  task automatic test_test_mode;
    do_reset;
    for (int b = 0; b < 2; b++) begin
      int bad = 0;
      logic [18:0] gv = 0, ev = 0;
      run_burst(1, BW + 2, 1, b == 0);
      for (int p = 1; p <= BW + 2; p++)
        if (bad == 0 && {c_ack[p], c_wr[p], c_done[p], c_data[p]} !== exp_vec(p, 1, 0)) begin
          bad = p; gv = {c_ack[p], c_wr[p], c_done[p], c_data[p]}; ev = exp_vec(p, 1, 0);
        end
      tests++;
      if (bad !== 0) begin failed++; $display("FAIL test_mode_burst%0d: period %0d got %h expected %h", b, bad, gv, ev); end
      if (b == 0) begin
        tests++;
        if ({c_data[2], c_data[3]} !== {16'h0000, 16'h0040}) begin
          failed++; $display("FAIL test_mode_start: got %h %h expected 0000 0040", c_data[2], c_data[3]);
        end
        tests++;
        if ({c_data[1025], c_data[1026]} !== {16'hFFC0, 16'h0000}) begin
          failed++; $display("FAIL test_mode_wrap: got %h %h expected ffc0 0000", c_data[1025], c_data[1026]);
        end
      end
      advance_model(1);
    end
    tm = 0;
  endtask

  task automatic test_input_drop;
    int bad = 0, nw = 0;
    logic [18:0] gv = 0, ev = 0;
    run_burst(0, BW + 2, 101, 0);
    for (int p = 1; p <= BW + 2; p++) begin
      nw += c_wr[p];
      if (bad == 0 && {c_ack[p], c_wr[p], c_done[p], c_data[p]} !== exp_vec(p, 0, 0)) begin
        bad = p; gv = {c_ack[p], c_wr[p], c_done[p], c_data[p]}; ev = exp_vec(p, 0, 0);
      end
    end
    tests++;
    if (bad !== 0) begin failed++; $display("FAIL drop_burst: period %0d got %h expected %h", bad, gv, ev); end
    tests++;
    if (nw !== BW) begin failed++; $display("FAIL drop_write_count: got %0d expected %0d", nw, BW); end
    advance_model(0);
  endtask

  task automatic test_reset_mid_burst;
    int bad = 0, na = 0;
    logic [18:0] gv = 0, ev = 0;
    repeat (HO + 2) @(negedge clk);
    fifo_rdy = 1; fx3_rdy = 1; tm = 0;
    @(posedge clk);
    for (int p = 1; p <= 4001; p++) begin
      @(negedge clk);
      if (p == 1) begin fifo_rdy = 0; fx3_rdy = 0; end
    end
    tests++;
    if ({ack, wr} !== 2'b11) begin failed++; $display("FAIL midreset_active: got %b expected 11", {ack, wr}); end
    rst = 1;
    #1;
    tests++;
    if ({ack, wr, done, err, data} !== 20'h0) begin
      failed++; $display("FAIL midreset_outputs: got %h expected 00000", {ack, wr, done, err, data});
    end
    @(negedge clk); rst = 0; pat_model = 0; last_data = 0;
    repeat (5) begin @(negedge clk); na += ack; end
    tests++;
    if (na !== 0) begin failed++; $display("FAIL midreset_idle: got %0d acks expected 0", na); end
    run_burst(0, BW + 2, 1, 0);
    for (int p = 1; p <= BW + 2; p++)
      if (bad == 0 && {c_ack[p], c_wr[p], c_done[p], c_data[p]} !== exp_vec(p, 0, 0)) begin
        bad = p; gv = {c_ack[p], c_wr[p], c_done[p], c_data[p]}; ev = exp_vec(p, 0, 0);
      end
    tests++;
    if (bad !== 0) begin failed++; $display("FAIL midreset_next_burst: period %0d got %h expected %h", bad, gv, ev); end
    advance_model(0);
  endtask

  task automatic test_error_flag;
    @(negedge clk);
    fifo_err = 1;
    #1;
    tests++;
    if (err !== 1'b0) begin failed++; $display("FAIL error_early: got %b expected 0", err); end
    @(negedge clk);
    fifo_err = 0;
    tests++;
    if (err !== 1'b1) begin failed++; $display("FAIL error_set: got %b expected 1", err); end
    run_burst(0, BW + 2, 1, 0);
    tests++;
    if (err !== 1'b1) begin failed++; $display("FAIL error_sticky: got %b expected 1", err); end
    do_reset;
    tests++;
    if (err !== 1'b0) begin failed++; $display("FAIL error_clear: got %b expected 0", err); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) samp[i] = 10'($urandom);
    test_reset;
    test_basic;
    test_ready_gating;
    test_test_mode;
    test_input_drop;
    test_reset_mid_burst;
    test_error_flag;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time %0t reached limit 3000000", $time);
    $fatal(1);
  end
endmodule

// File: doc/fx3_stream_tx.md
# fx3_stream_tx

Transmit-side engine between the dual-clock sample FIFO read port and the FX3 GPIF bus. It runs in the FX3 clock domain and waits until the FIFO reports a full burst available and the FX3 DMA thread reports ready. It then streams exactly one burst of FIFO words to the FX3, scaling each 10-bit ADC sample to a 16-bit bus word, and holds off long enough for the FX3 thread flag to settle. It is the consumer of the FIFO's read-ahead acknowledge and data-ready handshake.

## Interface
Parameters:
- BURST_WORDS, 8192: words per burst; equals one FX3 DMA buffer of 16 KB.
- HOLDOFF_CYCLES, 4: idle cycles after each burst before fx3Ready is sampled again; minimum 1.

Ports:
- clock  in  1  FX3 GPIF clock; sole clock.
- reset  in  1  asynchronous, active-high reset.
- fifoDataReady  in  1  FIFO holds at least BURST_WORDS words.
- fifoError  in  1  FIFO full; samples being lost.
- fifoData  in  10  read-ahead FIFO head word, valid while fifoDataReady.
- fifoAck  out  1  consume the current head word this cycle.
- fx3Ready  in  1  FX3 DMA thread can accept a full burst.
- testMode  in  1  substitute a counting pattern for FIFO data.
- fx3Data  out  16  bus data.
- fx3Write  out  1  bus write strobe; one word per high cycle.
- burstDone  out  1  single-cycle pulse after the last word of a burst.
- errorFlag  out  1  sticky FIFO-overflow indication.

## Operation
- States: IDLE, BURST, HOLDOFF.
- IDLE: when fifoDataReady=1 and fx3Ready=1 in the same cycle, go to BURST. At that transition, latch testMode into burstTest for the whole burst.
- BURST: fifoAck=1 every cycle; it is decoded from the state register, not from inputs.
  - The word counter (13 bits for the default) increments each cycle.
  - When the counter reaches BURST_WORDS-1, go to HOLDOFF and clear the counter.
- HOLDOFF: fifoAck=0. Count HOLDOFF_CYCLES cycles, then go to IDLE.
- Each acknowledged word is registered onto the bus on the next cycle:
  - fx3Write=1.
  - fx3Data = {fifoData, 6'b0}, left-justified; 10'h3FF gives 16'hFFC0.
  - When burstTest=1: fx3Data = {pattern, 6'b0}. pattern is a 10-bit counter that increments once per transmitted word and wraps 1023 to 0. It persists across bursts and resets to 0.
  - The FIFO is still acknowledged in test mode, so FIFO levels behave identically.
- Mid-burst changes to fifoDataReady, fx3Ready or testMode are ignored; a burst, once started, always completes.
- errorFlag is set on any cycle where fifoError=1. Only reset clears it.
- Reset, at any time including mid-burst: state returns to IDLE; all counters clear; all outputs go to 0 immediately. A partial burst is abandoned.

## Timing
- Reset values: fifoAck=0, fx3Write=0, fx3Data=16'h0000, burstDone=0, errorFlag=0.
- Start latency: the ready condition is sampled at edge N. fifoAck is high for cycles N+1 to N+BURST_WORDS. fx3Write is high for cycles N+2 to N+BURST_WORDS+1.
- fx3Write is high for exactly BURST_WORDS consecutive cycles per burst, with no gaps.
- burstDone is high in the same cycle as the final fx3Write.
- Earliest next start-sample edge: N+BURST_WORDS+HOLDOFF_CYCLES.
- Between bursts, fx3Data holds its last value while fx3Write=0.
- errorFlag asserts one cycle after fifoError is sampled high.

## Structure
- Shared package fx3_pkg: state enum (IDLE, BURST, HOLDOFF), default burst length 8192, data scale shift of 6, bus width of 16.
- One natural sub-module, test_pattern_gen: a 10-bit wrapping counter with an advance enable and async reset.
- Everything else stays in fx3_stream_tx.

## Test plan
- Basic burst: assert fifoDataReady and fx3Ready with a FIFO model. Expect exactly 8192 fifoAck cycles, 8192 contiguous fx3Write cycles starting 1 cycle after the first ack, burstDone coincident with the last write, and data 16'h0040 for sample 1.
- Ready gating: fifoDataReady=1 with fx3Ready=0 for 100 cycles gives no fifoAck. Raising fx3Ready starts a burst with the timing above. After the burst, fx3Ready=1 is not acted on before HOLDOFF_CYCLES cycles have elapsed.
- Test mode: testMode=1 across two bursts gives data 16'h0000, 16'h0040, … incrementing. The pattern wraps 1023 (16'hFFC0) to 0 and continues into the second burst. Toggling testMode mid-burst has no effect.
- Mid-burst input drops: deassert fx3Ready and fifoDataReady at word 100. The burst still completes all 8192 words.
- Reset mid-burst: assert reset at word 4000. All outputs are 0 in the same cycle; after release, the state is IDLE and the next burst sends a full 8192 words.
- Error flag: a one-cycle fifoError pulse sets errorFlag on the next cycle. errorFlag stays set through later bursts and clears only on reset.
